// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt controller: N_IRQ synchronised edge-triggered lines, enables, pending, fixed priority.
// Latency: raw rise -> pend after SYNC_STAGES+1 edges; pend -> Exc one edge later (IDLE, line enabled).
// Backpressure: PENDING holds Exc until ExcAck; SERVICE holds off new takes until ERet.
//
// Ports:
//   clk, reset (async active-low)
//   ExtIRQ[N_IRQ]  raw requests (rising edge significant)   IrqEn[N_IRQ]  per-line enable
//   NotAnInstr     invalid opcode of current instruction    ERet / ExcAck handler return / vector ack
//   Exc            exception request                        EStatus[4]    cause (0001 IRQ, 0010 INV)
//   IrqId[ID_W]    handled line index                       ExtIAck[N_IRQ] one-cycle one-hot ack
//   IrqPending     pending vector                           DblFault      sticky nested-fault flag
module exc_irq_ctrl #(
  parameter  int N_IRQ       = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] ExtIRQ,
  input  logic [N_IRQ-1:0] IrqEn,
  input  logic             NotAnInstr,
  input  logic             ERet,
  input  logic             ExcAck,
  output logic             Exc,
  output logic [3:0]       EStatus,
  output logic [ID_W-1:0]  IrqId,
  output logic [N_IRQ-1:0] ExtIAck,
  output logic [N_IRQ-1:0] IrqPending,
  output logic             DblFault
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  // Synchroniser chain plus one extra flop for rising-edge detection.
  logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
  logic [N_IRQ-1:0] r_prev;
  logic [N_IRQ-1:0] w_edge;

  logic [N_IRQ-1:0] r_pend;
  logic [N_IRQ-1:0] w_req;
  logic [ID_W-1:0]  w_sel;

  state_t           r_state, w_state_nxt;
  logic             r_cause_inv, w_cause_inv_nxt;
  logic [ID_W-1:0]  r_id, w_id_nxt;
  logic [N_IRQ-1:0] r_ack, w_ack_nxt;
  logic             r_dbl, w_dbl_nxt;
  logic [N_IRQ-1:0] w_clr;
  logic [N_IRQ-1:0] w_id_onehot;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= ExtIRQ;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

  // Lowest enabled pending index wins.
  assign w_req = r_pend & IrqEn;

  always_comb begin
    w_sel = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_req[i]) w_sel = ID_W'(i);
    end
  end

  assign w_id_onehot = {{(N_IRQ-1){1'b0}}, 1'b1} << r_id;

  always_comb begin
    w_state_nxt     = r_state;
    w_cause_inv_nxt = r_cause_inv;
    w_id_nxt        = r_id;
    w_ack_nxt       = '0;
    w_clr           = '0;
    w_dbl_nxt       = r_dbl;
    case (r_state)
      S_IDLE: begin
        // An invalid opcode pre-empts any IRQ; the losing IRQ stays pending.
        if (NotAnInstr) begin
          w_state_nxt     = S_PENDING;
          w_cause_inv_nxt = 1'b1;
        end else if (|w_req) begin
          w_state_nxt     = S_PENDING;
          w_cause_inv_nxt = 1'b0;
          w_id_nxt        = w_sel;
        end
      end
      S_PENDING: begin
        if (ExcAck) begin
          w_state_nxt = S_SERVICE;
          if (!r_cause_inv) begin
            w_ack_nxt = w_id_onehot;
            w_clr     = w_id_onehot;
          end
        end
      end
      S_SERVICE: begin
        if (NotAnInstr) w_dbl_nxt = 1'b1;
        if (ERet) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cause_inv <= 1'b0;
      r_id        <= '0;
      r_ack       <= '0;
      r_dbl       <= 1'b0;
      r_pend      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cause_inv <= w_cause_inv_nxt;
      r_id        <= w_id_nxt;
      r_ack       <= w_ack_nxt;
      r_dbl       <= w_dbl_nxt;
      // A new edge on the line being acknowledged re-arms it (set wins).
      r_pend      <= (r_pend & ~w_clr) | w_edge;
    end
  end

  assign Exc        = (r_state == S_PENDING);
  assign EStatus    = (r_state == S_IDLE) ? 4'b0000 :
                      (r_cause_inv        ? 4'b0010 : 4'b0001);
  assign IrqId      = r_id;
  assign ExtIAck    = r_ack;
  assign IrqPending = r_pend;
  assign DblFault   = r_dbl;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Bench for exc_irq_ctrl (N_IRQ=4, SYNC_STAGES=2): directed table, corner sequences, random run vs model.
// Latency: inputs applied before an edge, outputs sampled 1 time unit after it.
// Backpressure: none; every step is a fixed single clock.
module tb_exc_irq_ctrl;
  localparam int N = 4;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] ExtIRQ, IrqEn;
  logic       NotAnInstr, ERet, ExcAck;
  logic       Exc;
  logic [3:0] EStatus;
  logic [1:0] IrqId;
  logic [3:0] ExtIAck, IrqPending;
  logic       DblFault;

  exc_irq_ctrl #(.N_IRQ(N), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .ExtIRQ(ExtIRQ), .IrqEn(IrqEn),
    .NotAnInstr(NotAnInstr), .ERet(ERet), .ExcAck(ExcAck),
    .Exc(Exc), .EStatus(EStatus), .IrqId(IrqId), .ExtIAck(ExtIAck),
    .IrqPending(IrqPending), .DblFault(DblFault)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: history of raw request values, phase 0/1/2 = idle/exception raised/in handler.
  logic [3:0] h [S+2];
  int         m_phase;
  bit         m_inv;
  int         m_id;
  logic [3:0] m_pend, m_ack;
  bit         m_dbl;

  function automatic logic [15:0] pk(input logic exc, input logic [3:0] es, input logic [1:0] id,
                                     input logic [3:0] iack, input logic [3:0] pend, input logic dbl);
    return {exc, es, id, iack, pend, dbl};
  endfunction

  function automatic logic [15:0] dut_out();
    return pk(Exc, EStatus, IrqId, ExtIAck, IrqPending, DblFault);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < S + 2; k++) h[k] = 4'b0;
    m_phase = 0; m_inv = 1'b0; m_id = 0; m_pend = 4'b0; m_ack = 4'b0; m_dbl = 1'b0;
  endfunction

  function automatic void model_edge();
    logic [3:0] rise, req, ack;
    for (int k = S + 1; k > 0; k--) h[k] = h[k-1];
    h[0] = ExtIRQ;
    // a rise of the raw line seen S edges ago is latched now
    rise = h[S] & ~h[S+1];
    ack  = 4'b0;
    case (m_phase)
      0: begin
        req = m_pend & IrqEn;
        if (NotAnInstr) begin
          m_phase = 1; m_inv = 1'b1;
        end else if (req != 4'b0) begin
          m_phase = 1; m_inv = 1'b0;
          m_id = 0;
          while (req[m_id] == 1'b0) m_id++;
        end
      end
      1: if (ExcAck) begin
        m_phase = 2;
        if (!m_inv) ack = 4'b1 << m_id;
      end
      default: begin
        if (NotAnInstr) m_dbl = 1'b1;
        if (ERet) m_phase = 0;
      end
    endcase
    m_pend = (m_pend & ~ack) | rise;
    m_ack  = ack;
  endfunction

  function automatic logic [15:0] model_out();
    logic [3:0] es;
    es = (m_phase == 0) ? 4'b0000 : (m_inv ? 4'b0010 : 4'b0001);
    return pk(m_phase == 1, es, m_id[1:0], m_ack, m_pend, m_dbl);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] irq, input logic [3:0] en,
                       input logic nai, input logic eret, input logic ack);
    ExtIRQ = irq; IrqEn = en; NotAnInstr = nai; ERet = eret; ExcAck = ack;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", dut_out(), model_out());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    chk("reset_outs", dut_out(), 16'h0000);
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  irq;
    logic [3:0]  en;
    logic        nai;
    logic        eret;
    logic        ack;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [12];
  int   ack_cnt;

  initial begin
    // single IRQ on line 2, then INV + nested fault, then ignored ExcAck in IDLE
    tbl[0]  = '{4'b0100, 4'b1111, 1'b0, 1'b0, 1'b0, pk(1'b0, 4'd0, 2'd0, 4'b0000, 4'b0000, 1'b0)};
    tbl[1]  = '{4'b0100, 4'b1111, 1'b0, 1'b0, 1'b0, pk(1'b0, 4'd0, 2'd0, 4'b0000, 4'b0000, 1'b0)};
    tbl[2]  = '{4'b0100, 4'b1111, 1'b0, 1'b0, 1'b0, pk(1'b0, 4'd0, 2'd0, 4'b0000, 4'b0100, 1'b0)};
    tbl[3]  = '{4'b0100, 4'b1111, 1'b0, 1'b0, 1'b0, pk(1'b1, 4'd1, 2'd2, 4'b0000, 4'b0100, 1'b0)};
    tbl[4]  = '{4'b0100, 4'b1111, 1'b0, 1'b0, 1'b1, pk(1'b0, 4'd1, 2'd2, 4'b0100, 4'b0000, 1'b0)};
    tbl[5]  = '{4'b0100, 4'b1111, 1'b0, 1'b0, 1'b0, pk(1'b0, 4'd1, 2'd2, 4'b0000, 4'b0000, 1'b0)};
    tbl[6]  = '{4'b0100, 4'b1111, 1'b0, 1'b1, 1'b0, pk(1'b0, 4'd0, 2'd2, 4'b0000, 4'b0000, 1'b0)};
    tbl[7]  = '{4'b0100, 4'b1111, 1'b1, 1'b0, 1'b0, pk(1'b1, 4'd2, 2'd2, 4'b0000, 4'b0000, 1'b0)};
    tbl[8]  = '{4'b0100, 4'b1111, 1'b0, 1'b0, 1'b1, pk(1'b0, 4'd2, 2'd2, 4'b0000, 4'b0000, 1'b0)};
    tbl[9]  = '{4'b0100, 4'b1111, 1'b1, 1'b0, 1'b0, pk(1'b0, 4'd2, 2'd2, 4'b0000, 4'b0000, 1'b1)};
    tbl[10] = '{4'b0100, 4'b1111, 1'b0, 1'b1, 1'b0, pk(1'b0, 4'd0, 2'd2, 4'b0000, 4'b0000, 1'b1)};
    tbl[11] = '{4'b0100, 4'b1111, 1'b0, 1'b0, 1'b1, pk(1'b0, 4'd0, 2'd2, 4'b0000, 4'b0000, 1'b1)};

    drive(4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    do_reset();

    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].irq, tbl[k].en, tbl[k].nai, tbl[k].eret, tbl[k].ack);
      step();
      chk($sformatf("tbl[%0d]", k), dut_out(), tbl[k].exp);
    end

    // DblFault only cleared by reset
    drive(4'b0, 4'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    step();
    chk("dbl_cleared", 16'(DblFault), 16'h0);

    // priority: INV beats pending 1010, then IRQ1, then IRQ3
    drive(4'b1010, 4'b0000, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    chk("prio_pend", 16'(IrqPending), 16'h000A);
    drive(4'b1010, 4'b1111, 1'b1, 1'b0, 1'b0); step();
    chk("prio_inv_es", 16'(EStatus), 16'h0002);
    chk("prio_inv_pend", 16'(IrqPending), 16'h000A);
    drive(4'b1010, 4'b1111, 1'b0, 1'b0, 1'b1); step();
    chk("prio_inv_noack", 16'(ExtIAck), 16'h0000);
    drive(4'b1010, 4'b1111, 1'b0, 1'b1, 1'b0); step();
    drive(4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0); step();
    chk("prio_first_id", 16'({EStatus, IrqId}), 16'h0005);
    drive(4'b1010, 4'b1111, 1'b0, 1'b0, 1'b1); step();
    chk("prio_first_ack", 16'({ExtIAck, IrqPending}), 16'h0028);
    drive(4'b1010, 4'b1111, 1'b0, 1'b1, 1'b0); step();
    drive(4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0); step();
    chk("prio_second_id", 16'(IrqId), 16'h0003);
    drive(4'b1010, 4'b1111, 1'b0, 1'b0, 1'b1); step();
    chk("prio_second_ack", 16'({ExtIAck, IrqPending}), 16'h0080);
    drive(4'b1010, 4'b1111, 1'b0, 1'b1, 1'b0); step();

    // masking: disabled line latches pending but does not raise Exc
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    do_reset();
    drive(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    repeat (6) step();
    chk("mask_pend", 16'(IrqPending), 16'h0001);
    chk("mask_noexc", 16'(Exc), 16'h0000);
    drive(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0); step();
    chk("mask_enable_exc", 16'(Exc), 16'h0001);

    // re-rise on a pending line yields a single acknowledge
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    do_reset();
    drive(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0); repeat (3) step();
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0); repeat (2) step();
    drive(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0); repeat (4) step();
    chk("rerise_pend", 16'(IrqPending), 16'h0002);
    ack_cnt = 0;
    drive(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0); step();
    ack_cnt += int'(ExtIAck[1]);
    drive(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1); step();
    ack_cnt += int'(ExtIAck[1]);
    drive(4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0); step();
    ack_cnt += int'(ExtIAck[1]);
    drive(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      ack_cnt += int'(ExtIAck[1]);
    end
    chk("rerise_ack_count", 16'(ack_cnt), 16'd1);
    chk("rerise_pend_clear", 16'({Exc, IrqPending}), 16'h0000);

    // reset in the middle of PENDING with pend=0101
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    do_reset();
    drive(4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0); repeat (3) step();
    drive(4'b0101, 4'b0000, 1'b1, 1'b0, 1'b0); step();
    chk("midpend_state", 16'({Exc, IrqPending}), 16'h0015);
    drive(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    do_reset();
    step();
    chk("post_reset_idle", 16'({Exc, EStatus}), 16'h0000);

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] flip;
      flip = 4'b0;
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 5) == 0);
      drive(ExtIRQ ^ flip,
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111,
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
